// File: rtl/arm_pkg.sv
// arm_pkg: shared encodings and defaults for the MEM-stage SRAM controller
package arm_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int DATA_BASE_DEF = 1024;
  localparam int SRAM_DQ_W = 16;
endpackage

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: moves 32-bit words to/from a 16-bit async SRAM as two half-word accesses
module sram_mem_ctrl
  import arm_pkg::*;
#(
  parameter int DATA_BASE = DATA_BASE_DEF,
  parameter int SRAM_ADDR_W = 18,
  parameter int ACCESS_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [SRAM_DQ_W-1:0]   sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DQ_W-1:0]   sram_dq_in
);
  logic [2:0] state;
  logic [7:0] cnt;
  logic [31:0] off;
  logic [SRAM_ADDR_W-1:0] addr_q, hw_addr;
  logic req, rd, xfer, unused_bits;
  assign req = wr_en | rd_en;
  assign rd = rd_en & ~wr_en;
  assign xfer = (state == S_LO) || (state == S_HI);
  assign off = address - 32'(DATA_BASE);
  // word index shifted up one bit, truncated so out-of-range addresses wrap
  assign hw_addr = {off[SRAM_ADDR_W:2], state == S_HI};
  assign unused_bits = ^{off[31:SRAM_ADDR_W+1], off[1:0]};
  assign ready = ~req | (state == S_DONE);
  assign sram_addr = xfer ? hw_addr : addr_q;
  assign sram_dq_oe = xfer & wr_en;
  assign sram_we_n = ~sram_dq_oe;
  assign sram_dq_out = sram_dq_oe ? ((state == S_HI) ? write_data[31:16] : write_data[15:0]) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      addr_q <= '0;
      read_data <= '0;
    end else begin
      if (xfer) addr_q <= hw_addr;
      if (state == S_LO && rd) read_data[15:0] <= sram_dq_in;
      if (state == S_HI && rd) read_data[31:16] <= sram_dq_in;
      state <= (state == S_IDLE) ? (req ? S_LO : S_IDLE) :
               (state == S_LO)   ? S_HI :
               (state == S_HI)   ? ((ACCESS_CYCLES == 3) ? S_DONE : S_WAIT) :
               (state == S_WAIT) ? ((cnt == 8'd1) ? S_DONE : S_WAIT) : S_IDLE;
      cnt <= (state == S_HI) ? 8'(ACCESS_CYCLES - 3) : (state == S_WAIT) ? cnt - 8'd1 : cnt;
    end
  end
endmodule
